// File: rtl/myo_spi_responder.sv
// SPI mode-0 slave for the 12-word myo control frame: receives command words 0..3,
// returns a coherent snapshot of the status inputs in words 5..11.
module myo_spi_responder #(
  parameter logic [15:0] SOF_WORD       = 16'h8000,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sck,
  input  logic        mosi,
  input  logic        ss_n,
  output logic        miso,
  output logic        miso_oe,
  input  logic [31:0] actual_position,
  input  logic [15:0] actual_velocity,
  input  logic [15:0] actual_current,
  input  logic [15:0] spring_displacement,
  input  logic [15:0] sensor1,
  input  logic [15:0] sensor2,
  output logic [15:0] pwm_ref,
  output logic [15:0] control_flags1,
  output logic [15:0] control_flags2,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        comm_timeout
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SNAP_W = 112;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0] FRAME_WORDS = 4'd12;
  localparam logic [3:0] WORD_SAT    = 4'd13;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state;
  logic [1:0]          sck_sync, mosi_sync, ss_sync;
  logic                sck_q, ss_q;
  logic [SNAP_W-1:0]   snap;
  logic [WORD_W-1:0]   rx_sr, tx_sr;
  logic [WORD_W-1:0]   shadow [4];
  logic [3:0]          bit_cnt, word_cnt;
  logic [CNT_W-1:0]    tmo_cnt;

  logic                sck_rise_c, sck_fall_c, ss_fall_c, ss_rise_c;
  logic [WORD_W-1:0]   rx_word_c;
  logic [3:0]          word_next_c;
  logic                commit_good_c;

  assign sck_rise_c    = sck_sync[1] & ~sck_q;
  assign sck_fall_c    = ~sck_sync[1] & sck_q;
  assign ss_fall_c     = ~ss_sync[1] & ss_q;
  assign ss_rise_c     = ss_sync[1] & ~ss_q;
  assign rx_word_c     = {rx_sr[WORD_W-2:0], mosi_sync[1]};
  assign word_next_c   = (word_cnt == WORD_SAT) ? WORD_SAT : word_cnt + 4'd1;
  assign commit_good_c = (state == COMMIT) && (word_cnt == FRAME_WORDS) &&
                         (bit_cnt == 4'd0) && (shadow[0] == SOF_WORD);
  assign miso          = tx_sr[WORD_W-1];

  // Status word for a given frame slot; slots outside 5..11 transmit zero.
  function automatic logic [WORD_W-1:0] tx_word(input logic [3:0] idx,
                                                input logic [SNAP_W-1:0] s);
    case (idx)
      4'd5:    tx_word = s[111:96];
      4'd6:    tx_word = s[95:80];
      4'd7:    tx_word = s[79:64];
      4'd8:    tx_word = s[63:48];
      4'd9:    tx_word = s[47:32];
      4'd10:   tx_word = s[31:16];
      4'd11:   tx_word = s[15:0];
      default: tx_word = '0;
    endcase
  endfunction

  // Two-flop synchronisers plus previous-value registers for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      ss_sync   <= 2'b11;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_sync   <= {ss_sync[0], ss_n};
      sck_q     <= sck_sync[1];
      ss_q      <= ss_sync[1];
    end
  end

  // Frame FSM: shifting, word capture, commit/reject.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      snap           <= '0;
      rx_sr          <= '0;
      tx_sr          <= '0;
      bit_cnt        <= '0;
      word_cnt       <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      miso_oe        <= 1'b0;
      pwm_ref        <= '0;
      control_flags1 <= '0;
      control_flags2 <= '0;
      frame_valid    <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall_c) begin
            state    <= SHIFT;
            snap     <= {actual_position, actual_velocity, actual_current,
                         spring_displacement, sensor1, sensor2};
            bit_cnt  <= '0;
            word_cnt <= '0;
            tx_sr    <= '0;
            miso_oe  <= 1'b1;
          end
        end
        SHIFT: begin
          if (ss_rise_c) begin
            state   <= COMMIT;
            miso_oe <= 1'b0;
          end else if (sck_rise_c) begin
            rx_sr   <= rx_word_c;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              if (word_cnt < 4'd4) shadow[word_cnt[1:0]] <= rx_word_c;
              word_cnt <= word_next_c;
              tx_sr    <= tx_word(word_next_c, snap);
            end
          end else if (sck_fall_c && bit_cnt != 4'd0) begin
            // First bit of each word is already on miso from the load.
            tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (commit_good_c) begin
            pwm_ref        <= shadow[1] & 16'h7fff;
            control_flags1 <= shadow[2];
            control_flags2 <= shadow[3];
            frame_valid    <= 1'b1;
          end else begin
            frame_error    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Link watchdog; a good commit in the same cycle takes precedence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt      <= '0;
      comm_timeout <= 1'b0;
    end else if (commit_good_c) begin
      tmo_cnt      <= '0;
      comm_timeout <= 1'b0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt      <= tmo_cnt + CNT_W'(1);
      comm_timeout <= ((tmo_cnt + CNT_W'(1)) == TMO_MAX);
    end else begin
      comm_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_myo_spi_responder.sv
// Directed bench for myo_spi_responder: SPI master model, MISO scoreboard,
// and a commit model for the command outputs and pulse counts.
module tb_myo_spi_responder;

  localparam int unsigned TMO  = 100;
  localparam int          HALF = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        ss_n = 1'b1;
  logic        miso, miso_oe;
  logic [31:0] pos = 32'h0001_2345;
  logic [15:0] vel = 16'hFFFD;
  logic [15:0] cur = 16'h0102;
  logic [15:0] spr = 16'h0304;
  logic [15:0] s1  = 16'hFFFF;
  logic [15:0] s2  = 16'h7001;
  logic [15:0] pwm_ref, control_flags1, control_flags2;
  logic        frame_valid, frame_error, comm_timeout;

  logic [15:0] tx_words [16];
  logic [15:0] exp_q [$];
  int          npass = 0;
  int          ntotal = 0;
  int          n_valid = 0;
  int          n_err = 0;
  logic        ct_at_valid = 1'b1;
  logic [15:0] m_pwm = 16'h0, m_cf1 = 16'h0, m_cf2 = 16'h0;
  int          m_valid = 0;
  int          m_err = 0;

  always #5 clock = ~clock;

  myo_spi_responder #(.SOF_WORD(16'h8000), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .sck(sck), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe),
    .actual_position(pos), .actual_velocity(vel), .actual_current(cur),
    .spring_displacement(spr), .sensor1(s1), .sensor2(s2),
    .pwm_ref(pwm_ref), .control_flags1(control_flags1), .control_flags2(control_flags2),
    .frame_valid(frame_valid), .frame_error(frame_error), .comm_timeout(comm_timeout)
  );

  always @(posedge clock) begin
    if (frame_valid) begin
      n_valid++;
      ct_at_valid = comm_timeout;
    end
    if (frame_error) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] tx_model(input int i);
    case (i)
      5:       return pos[31:16];
      6:       return pos[15:0];
      7:       return vel;
      8:       return cur;
      9:       return spr;
      10:      return s1;
      11:      return s2;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic load_words(input logic [15:0] sof, input logic [15:0] pw,
                            input logic [15:0] f1, input logic [15:0] f2);
    tx_words[0] = sof; tx_words[1] = pw; tx_words[2] = f1; tx_words[3] = f2;
    for (int i = 4; i < 16; i++) tx_words[i] = (i == 4) ? 16'h0000 : 16'hA500 + 16'(i);
  endtask

  task automatic half_sck();
    repeat (HALF) @(negedge clock);
  endtask

  task automatic spi_frame(input int nwords, input int extra, input bit chg);
    logic [15:0] w, got, exp;
    int nb;
    for (int i = 0; i < nwords; i++) exp_q.push_back(tx_model(i));
    @(negedge clock) ss_n = 1'b0;
    repeat (6) @(negedge clock);
    check("miso_oe_selected", 32'(miso_oe), 32'd1);
    got = '0;
    for (int i = 0; i <= nwords; i++) begin
      nb = (i < nwords) ? 16 : extra;
      if (nb == 0) break;
      w = tx_words[i];
      for (int b = 0; b < nb; b++) begin
        mosi = w[15-b];
        half_sck();
        got = {got[14:0], miso};
        sck = 1'b1;
        half_sck();
        sck = 1'b0;
      end
      if (nb == 16) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
        else begin
          exp = exp_q.pop_front();
          check($sformatf("miso_word%0d", i), 32'(got), 32'(exp));
        end
      end
      if (chg && i == 2) begin
        pos = 32'hDEAD_BEEF; vel = 16'h1111; cur = 16'h2222;
        spr = 16'h3333; s1 = 16'h4444; s2 = 16'h5555;
      end
    end
    half_sck();
    ss_n = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  task automatic frame_and_check(input string tag, input int nwords, input int extra, input bit chg);
    bit accept;
    spi_frame(nwords, extra, chg);
    accept = (nwords == 12) && (extra == 0) && (tx_words[0] == 16'h8000);
    if (accept) begin
      m_pwm = tx_words[1] & 16'h7fff; m_cf1 = tx_words[2]; m_cf2 = tx_words[3];
      m_valid++;
    end else m_err++;
    check({tag, "_pwm_ref"}, 32'(pwm_ref), 32'(m_pwm));
    check({tag, "_flags1"}, 32'(control_flags1), 32'(m_cf1));
    check({tag, "_flags2"}, 32'(control_flags2), 32'(m_cf2));
    check({tag, "_valid_cnt"}, 32'(n_valid), 32'(m_valid));
    check({tag, "_error_cnt"}, 32'(n_err), 32'(m_err));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tx_words[i] = '0;
    repeat (3) @(negedge clock);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_pwm_ref", 32'(pwm_ref), 32'd0);
    check("rst_flags", {control_flags1, control_flags2}, 32'd0);
    check("rst_pulses", {30'd0, frame_valid, frame_error}, 32'd0);
    check("rst_timeout", 32'(comm_timeout), 32'd0);
    reset_n = 1'b1;

    repeat (TMO - 1) @(posedge clock);
    #1 check("timeout_before", 32'(comm_timeout), 32'd0);
    @(posedge clock);
    #1 check("timeout_at", 32'(comm_timeout), 32'd1);

    load_words(16'h8000, 16'h1234, 16'h00A5, 16'h0F0F);
    frame_and_check("good", 12, 0, 1'b0);
    check("timeout_cleared_at_commit", 32'(ct_at_valid), 32'd0);

    load_words(16'h8000, 16'hFFFF, 16'h5A5A, 16'hC3C3);
    frame_and_check("pwm_mask", 12, 0, 1'b0);

    load_words(16'h8001, 16'h0777, 16'h1111, 16'h2222);
    frame_and_check("bad_sof", 12, 0, 1'b0);

    load_words(16'h8000, 16'h0555, 16'h3333, 16'h4444);
    frame_and_check("short11", 11, 0, 1'b0);
    frame_and_check("partial", 12, 5, 1'b0);
    frame_and_check("long13", 13, 0, 1'b0);

    load_words(16'h8000, 16'h0ABC, 16'h00F0, 16'hF000);
    frame_and_check("status_chg", 12, 0, 1'b1);

    // Abort a frame with reset in the middle of word 1.
    load_words(16'h8000, 16'h0321, 16'h0001, 16'h0002);
    @(negedge clock) ss_n = 1'b0;
    repeat (6) @(negedge clock);
    for (int b = 0; b < 20; b++) begin
      mosi = tx_words[b / 16][15 - (b % 16)];
      half_sck();
      sck = 1'b1;
      half_sck();
      sck = 1'b0;
    end
    @(negedge clock);
    reset_n = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    #1;
    check("midrst_miso_oe", 32'(miso_oe), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_pwm_ref", 32'(pwm_ref), 32'd0);
    check("midrst_flags", {control_flags1, control_flags2}, 32'd0);
    check("midrst_timeout", 32'(comm_timeout), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check("midrst_valid_cnt", 32'(n_valid), 32'(m_valid));
    check("midrst_error_cnt", 32'(n_err), 32'(m_err));
    check("midrst_pwm_after", 32'(pwm_ref), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
